// File: rtl/apb3_slave_regfile.sv
// APB3 completer: NUM_REGS RW registers plus a read-only ID word,
// fixed wait-state insertion, pslverr on illegal accesses.
//
// Ports:
//   pclk, prst_n     clock, synchronous active-low reset
//   psel, penable    APB3 select / access-phase enable
//   pwrite           1 = write, 0 = read
//   paddr, pwdata    byte address and write data
//   prdata           read data, valid in the completion cycle
//   pready           transfer complete / slave ready
//   pslverr          error response, valid in the completion cycle
//   reg_q            flat register contents, reg i at [i*DW +: DW]
//   wr_strobe        one-cycle pulse per committed register write
//   wr_index         index of the register written with wr_strobe
module apb3_slave_regfile #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE = 32'hA5B3_0001
) (
    input  logic                           pclk,
    input  logic                           prst_n,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pready,
    output logic                           pslverr,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic                           wr_strobe,
    output logic [$clog2(NUM_REGS)-1:0]    wr_index
);

    localparam int unsigned IW = $clog2(NUM_REGS);
    localparam int unsigned WW = ADDR_WIDTH - 2;
    localparam logic [3:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                               state;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs;
    logic [3:0]                           cnt;

    // Transfer attributes captured in the setup phase
    logic                  l_wr;
    logic                  l_err;
    logic                  l_id;
    logic [IW-1:0]         l_idx;
    logic [DATA_WIDTH-1:0] l_wdata;

    // Live decode of the bus address
    logic [WW-1:0] word;
    logic          d_rw;
    logic          d_id;
    logic          d_err;
    logic [IW-1:0] d_idx;

    assign word  = paddr[ADDR_WIDTH-1:2];
    assign d_idx = paddr[IW+1:2];
    assign reg_q = regs;

    always_comb begin
        d_rw  = 32'(word) < NUM_REGS;
        d_id  = 32'(word) == NUM_REGS;
        d_err = (paddr[1:0] != 2'b00)
              | ~(d_rw | d_id)
              | (pwrite & d_id);
    end

    // Writes and errored accesses return zero on prdata
    function automatic logic [DATA_WIDTH-1:0] rd_val(
        input logic          wr,
        input logic          err,
        input logic          id,
        input logic [IW-1:0] idx
    );
        if (wr || err)
            return '0;
        else if (id)
            return ID_VALUE;
        else
            return regs[idx];
    endfunction

    always_ff @(posedge pclk) begin
        if (!prst_n) begin
            state     <= S_IDLE;
            regs      <= '0;
            cnt       <= '0;
            prdata    <= '0;
            pready    <= 1'b1;
            pslverr   <= 1'b0;
            wr_strobe <= 1'b0;
            wr_index  <= '0;
            l_wr      <= 1'b0;
            l_err     <= 1'b0;
            l_id      <= 1'b0;
            l_idx     <= '0;
            l_wdata   <= '0;
        end else begin
            wr_strobe <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    // penable without a prior setup is ignored here
                    if (psel && !penable) begin
                        l_wr    <= pwrite;
                        l_err   <= d_err;
                        l_id    <= d_id;
                        l_idx   <= d_idx;
                        l_wdata <= pwdata;
                        if (WAIT_CYCLES == 0) begin
                            state   <= S_RESP;
                            prdata  <= rd_val(pwrite, d_err,
                                              d_id, d_idx);
                            pslverr <= d_err;
                        end else begin
                            state  <= S_WAIT;
                            pready <= 1'b0;
                            cnt    <= CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!psel) begin
                        state  <= S_IDLE;
                        pready <= 1'b1;
                    end else if (cnt == 4'd0) begin
                        state   <= S_RESP;
                        pready  <= 1'b1;
                        prdata  <= rd_val(l_wr, l_err, l_id, l_idx);
                        pslverr <= l_err;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    state   <= S_IDLE;
                    pready  <= 1'b1;
                    prdata  <= '0;
                    pslverr <= 1'b0;
                    // A dropped psel abandons the transfer uncommitted
                    if (psel && l_wr && !l_err) begin
                        regs[l_idx] <= l_wdata;
                        wr_strobe   <= 1'b1;
                        wr_index    <= l_idx;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    pready <= 1'b1;
                end
            endcase
        end
    end

endmodule
